// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the single-cycle RV32I core.
// Holds the base opcodes, the funct3 codes used by the decoder, the ALU
// operation type and the canonical NOP encoding.
// No ports.
package rv32i_pkg;

   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;

   // OP / OP-IMM
   localparam logic [2:0] F3_ADD_SUB = 3'd0;
   localparam logic [2:0] F3_SLL     = 3'd1;
   localparam logic [2:0] F3_SLT     = 3'd2;
   localparam logic [2:0] F3_SLTU    = 3'd3;
   localparam logic [2:0] F3_XOR     = 3'd4;
   localparam logic [2:0] F3_SRL_SRA = 3'd5;
   localparam logic [2:0] F3_OR      = 3'd6;

   // BRANCH
   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   // LOAD / STORE
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/rv32i_cpu_top_regfile.sv
// cpu_regfile: 32 x 32-bit integer register file.
// Ports: clk, rst (sync active-low, clears all registers),
//        rs1_addr/rs2_addr -> rs1_data/rs2_data (combinational, x0 reads 0),
//        rd_we/rd_addr/rd_data (write on posedge, writes to x0 dropped).
module cpu_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic        rd_we,
   input  logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data
);

   logic [31:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (rd_we && (rd_addr != 5'd0)) begin
         regs[rd_addr] <= rd_data;
      end
   end

   assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rv32i_cpu_top.sv
// rv32i_cpu_top: single-cycle RV32I core (fetch, decode, execute, memory
// access and writeback all complete in one clk cycle).
// Ports: clk (all state on posedge), rst (synchronous, active-low).
// Program lives in an internal ROM that is preloaded hierarchically.
// Optional build macro CPU_EBREAK_HALT_EN: EBREAK halts the core until reset.
module rv32i_cpu_top
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          IMEM_DEPTH     = 1024,
   parameter int          DMEM_DEPTH     = 1024,
   parameter string       IMEM_INIT_FILE = "program.hex"
) (
   input  logic clk,
   input  logic rst
);

   localparam int IA_W = $clog2(IMEM_DEPTH);
   localparam int DA_W = $clog2(DMEM_DEPTH);

   logic [31:0] imem [0:IMEM_DEPTH-1];
   logic [31:0] dmem [0:DMEM_DEPTH-1];

   logic [31:0] pc, pc_next, inst, imm, rs1_data, rs2_data, alu_out;
   logic [31:0] alu_a, alu_b, pc_plus4, pc_imm, rd_data, load_word, load_data;
   logic [31:0] st_data;
   logic [15:0] load_half;
   logic [7:0]  load_byte;
   logic [3:0]  st_be;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [DA_W-1:0] dmem_idx;
   logic        rd_we, mem_we, br_taken, hold;
   alu_op_e     alu_op;

   assign inst   = (pc[31:2] < 30'(IMEM_DEPTH)) ? imem[pc[IA_W+1:2]] : NOP_INST;
   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];

`ifdef CPU_EBREAK_HALT_EN
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
   logic halted;

   always_ff @(posedge clk) begin
      if (!rst)                     halted <= 1'b0;
      else if (inst == EBREAK_INST) halted <= 1'b1;
   end

   // The EBREAK itself already stalls, so pc stays on the EBREAK address.
   assign hold = halted || (inst == EBREAK_INST);
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      imm = '0;
      case (opcode)
         OP_IMM, LOAD, JALR: imm = {{20{inst[31]}}, inst[31:20]};
         STORE:              imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         BRANCH:             imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         LUI, AUIPC:         imm = {inst[31:12], 12'b0};
         JAL:                imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         default:            imm = '0;
      endcase
   end

   cpu_regfile regfile (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (inst[19:15]),
      .rs2_addr (inst[24:20]),
      .rd_we    (rd_we),
      .rd_addr  (inst[11:7]),
      .rd_data  (rd_data),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   always_comb begin
      alu_op = ALU_ADD;
      if ((opcode == OP) || (opcode == OP_IMM)) begin
         case (funct3)
            F3_ADD_SUB: alu_op = ((opcode == OP) && inst[30]) ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_op = ALU_SLL;
            F3_SLT:     alu_op = ALU_SLT;
            F3_SLTU:    alu_op = ALU_SLTU;
            F3_XOR:     alu_op = ALU_XOR;
            F3_SRL_SRA: alu_op = inst[30] ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_op = ALU_OR;
            default:    alu_op = ALU_AND;
         endcase
      end
   end

   assign alu_a = ((opcode == AUIPC) || (opcode == JAL)) ? pc : rs1_data;
   assign alu_b = ((opcode == OP) || (opcode == BRANCH)) ? rs2_data : imm;

   always_comb begin
      case (alu_op)
         ALU_SUB:  alu_out = alu_a - alu_b;
         ALU_SLL:  alu_out = alu_a << alu_b[4:0];
         ALU_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_out = {31'b0, alu_a < alu_b};
         ALU_XOR:  alu_out = alu_a ^ alu_b;
         ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_out = $signed(alu_a) >>> alu_b[4:0];
         ALU_OR:   alu_out = alu_a | alu_b;
         ALU_AND:  alu_out = alu_a & alu_b;
         default:  alu_out = alu_a + alu_b;
      endcase
   end

   always_comb begin
      case (funct3)
         F3_BEQ:  br_taken = (rs1_data == rs2_data);
         F3_BNE:  br_taken = (rs1_data != rs2_data);
         F3_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
         F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: br_taken = (rs1_data < rs2_data);
         F3_BGEU: br_taken = (rs1_data >= rs2_data);
         default: br_taken = 1'b0;
      endcase
   end

   assign pc_plus4 = pc + 32'd4;
   assign pc_imm   = pc + imm;

   always_comb begin
      pc_next = pc_plus4;
      case (opcode)
         BRANCH:  if (br_taken) pc_next = pc_imm;
         JAL:     pc_next = pc_imm;
         JALR:    pc_next = alu_out & ~32'd1;   // alu_out = rs1 + imm here
         default: pc_next = pc_plus4;
      endcase
      if (hold) pc_next = pc;
   end

   always_ff @(posedge clk) begin
      if (!rst) pc <= RESET_PC;
      else      pc <= pc_next;
   end

   // Data memory: word index wraps modulo depth; low address bits only
   // steer byte lanes, so misaligned halfwords/words are force-aligned.
   assign dmem_idx  = DA_W'(alu_out[31:2] % 30'(DMEM_DEPTH));
   assign load_word = dmem[dmem_idx];
   assign load_byte = 8'(load_word >> {alu_out[1:0], 3'b000});
   assign load_half = alu_out[1] ? load_word[31:16] : load_word[15:0];

   always_comb begin
      case (funct3)
         F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
         F3_H:    load_data = {{16{load_half[15]}}, load_half};
         F3_BU:   load_data = {24'b0, load_byte};
         F3_HU:   load_data = {16'b0, load_half};
         default: load_data = load_word;
      endcase
   end

   always_comb begin
      case (funct3)
         F3_B: begin
            st_be   = 4'b0001 << alu_out[1:0];
            st_data = {4{rs2_data[7:0]}};
         end
         F3_H: begin
            st_be   = alu_out[1] ? 4'b1100 : 4'b0011;
            st_data = {2{rs2_data[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = rs2_data;
         end
      endcase
   end

   assign mem_we = (opcode == STORE) && !hold;

   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) dmem[dmem_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      rd_we   = 1'b0;
      rd_data = alu_out;
      case (opcode)
         LUI:          begin rd_we = 1'b1; rd_data = imm;       end
         AUIPC:        begin rd_we = 1'b1; rd_data = pc_imm;    end
         JAL, JALR:    begin rd_we = 1'b1; rd_data = pc_plus4;  end
         OP, OP_IMM:   begin rd_we = 1'b1; rd_data = alu_out;   end
         LOAD:         begin rd_we = 1'b1; rd_data = load_data; end
         SYSTEM, MISC_MEM: rd_we = 1'b0;
         default:      rd_we = 1'b0;
      endcase
      if (hold) rd_we = 1'b0;
   end

endmodule

// File: tb/tb_rv32i_cpu_top.sv
// Scoreboard bench for rv32i_cpu_top: the driver loads small hand-assembled
// programs into the ROM, pulses reset and queues expected architectural
// state per cycle; the monitor compares at each negedge.
module tb_rv32i_cpu_top;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rv32i_cpu_top #(.IMEM_INIT_FILE("")) dut (.clk(clk), .rst(rst));

   typedef struct {
      int          cyc;
      int          kind;   // 0 pc, 1 reg, 2 alu_out, 3 pc_next
      int          idx;
      logic [31:0] val;
      int          tst;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] prog [0:63];
   int cyc = 0, base = 0, tst = 0;
   int n_checks = 0, n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] i_type(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] s_type(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] b_type(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] j_type(logic [20:0] imm, logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] probe(int kind, int idx);
      case (kind)
         0:       return dut.pc;
         1:       return dut.regfile.regs[idx[4:0]];
         2:       return dut.alu_out;
         default: return dut.pc_next;
      endcase
   endfunction

   function automatic string kname(int kind);
      case (kind)
         0:       return "pc";
         1:       return "reg";
         2:       return "alu_out";
         default: return "pc_next";
      endcase
   endfunction

   task automatic expect_at(int k, int kind, int idx, logic [31:0] v);
      exp_t e;
      e.cyc = base + k; e.kind = kind; e.idx = idx; e.val = v; e.tst = tst;
      sb_q.push_back(e);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 64; i++) prog[i] = NOP;
   endtask

   // Loads prog while reset is held, then releases; base marks the cycle in
   // which the instruction at address 0 is executing.
   task automatic start_prog();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) dut.imem[i] = (i < 64) ? prog[i] : NOP;
      @(negedge clk);
      rst  = 1'b1;
      base = cyc;
   endtask

   // Monitor
   initial begin
      exp_t        e;
      logic [31:0] got;
      forever begin
         @(negedge clk);
         #1;
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
               n_fail++;
               $display("FAIL t%0d %s[%0d]: check missed its cycle (due %0d, now %0d)",
                        e.tst, kname(e.kind), e.idx, e.cyc, cyc);
            end else begin
               got = probe(e.kind, e.idx);
               if (got !== e.val) begin
                  n_fail++;
                  $display("FAIL t%0d %s[%0d] @cyc %0d: got %h expected %h",
                           e.tst, kname(e.kind), e.idx, cyc, got, e.val);
               end
            end
         end
      end
   end

   // Driver
   initial begin
      // T1: reset state and sequential fetch over NOPs
      tst = 1; clear_prog(); start_prog();
      for (int r = 0; r < 32; r++) expect_at(0, 1, r, 32'h0);
      for (int k = 0; k < 4; k++) expect_at(k, 0, 0, 32'(4 * k));
      repeat (5) @(negedge clk);

      // T2: ADDI/ADD, x0 write discard, mid-program reset
      tst = 2; clear_prog();
      prog[0] = i_type(12'd5,   5'd0, 3'd0, 5'd1, 7'b0010011);
      prog[1] = i_type(12'hFFD, 5'd0, 3'd0, 5'd2, 7'b0010011);
      prog[2] = r_type(7'd0, 5'd2, 5'd1, 3'd0, 5'd3);
      prog[3] = i_type(12'd9,   5'd0, 3'd0, 5'd0, 7'b0010011);
      start_prog();
      expect_at(2, 2, 0, 32'd2);
      expect_at(3, 1, 1, 32'd5);
      expect_at(3, 1, 2, 32'hFFFF_FFFD);
      expect_at(3, 1, 3, 32'd2);
      expect_at(3, 2, 0, 32'd9);
      expect_at(4, 1, 0, 32'd0);
      expect_at(4, 0, 0, 32'd16);
      expect_at(6, 0, 0, 32'd0);
      expect_at(6, 1, 1, 32'd0);
      expect_at(6, 1, 2, 32'd0);
      expect_at(6, 1, 3, 32'd0);
      expect_at(7, 0, 0, 32'd4);
      expect_at(7, 1, 1, 32'd5);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // T3: JAL x1,+8 at pc 8, then JALR x0,0(x1)
      tst = 3; clear_prog();
      prog[0] = i_type(12'd1,  5'd0, 3'd0, 5'd5, 7'b0010011);
      prog[2] = j_type(21'd8, 5'd1);
      prog[3] = i_type(12'd33, 5'd0, 3'd0, 5'd6, 7'b0010011);
      prog[4] = i_type(12'd0,  5'd1, 3'd0, 5'd0, 7'b1100111);
      start_prog();
      expect_at(2, 0, 0, 32'd8);
      expect_at(2, 3, 0, 32'd16);
      expect_at(3, 0, 0, 32'd16);
      expect_at(3, 1, 1, 32'd12);
      expect_at(3, 3, 0, 32'd12);
      expect_at(4, 0, 0, 32'd12);
      expect_at(5, 1, 6, 32'd33);
      expect_at(5, 0, 0, 32'd16);
      repeat (7) @(negedge clk);

      // T4: BEQ +12 at 0x20, taken (7==7) and not taken (7!=8)
      for (int t = 0; t < 2; t++) begin
         tst = 4 + t; clear_prog();
         prog[0] = i_type(12'd7, 5'd0, 3'd0, 5'd1, 7'b0010011);
         prog[1] = i_type((t == 0) ? 12'd7 : 12'd8, 5'd0, 3'd0, 5'd2, 7'b0010011);
         prog[8] = b_type(13'd12, 5'd2, 5'd1, 3'd0);
         start_prog();
         expect_at(8, 0, 0, 32'h20);
         expect_at(8, 3, 0, (t == 0) ? 32'h2C : 32'h24);
         expect_at(9, 0, 0, (t == 0) ? 32'h2C : 32'h24);
         repeat (11) @(negedge clk);
      end

      // T6: SW then sub-word loads at offset 2, SB into byte 1
      tst = 6; clear_prog();
      prog[0]  = {20'h80818, 5'd1, 7'b0110111};
      prog[1]  = i_type(12'h283, 5'd1, 3'd0, 5'd1, 7'b0010011);
      prog[2]  = i_type(12'h100, 5'd0, 3'd0, 5'd2, 7'b0010011);
      prog[3]  = s_type(12'd0, 5'd1, 5'd2, 3'd2);
      prog[4]  = i_type(12'd2, 5'd2, 3'd0, 5'd3, 7'b0000011);
      prog[5]  = i_type(12'd2, 5'd2, 3'd4, 5'd4, 7'b0000011);
      prog[6]  = i_type(12'd2, 5'd2, 3'd1, 5'd5, 7'b0000011);
      prog[7]  = i_type(12'd2, 5'd2, 3'd5, 5'd6, 7'b0000011);
      prog[8]  = i_type(12'd0, 5'd2, 3'd2, 5'd7, 7'b0000011);
      prog[9]  = i_type(12'h55, 5'd0, 3'd0, 5'd9, 7'b0010011);
      prog[10] = s_type(12'd1, 5'd9, 5'd2, 3'd0);
      prog[11] = i_type(12'd0, 5'd2, 3'd2, 5'd8, 7'b0000011);
      start_prog();
      expect_at(2, 1, 1, 32'h8081_8283);
      expect_at(4, 2, 0, 32'h0000_0102);
      expect_at(12, 1, 3, 32'hFFFF_FF81);
      expect_at(12, 1, 4, 32'h0000_0081);
      expect_at(12, 1, 5, 32'hFFFF_8081);
      expect_at(12, 1, 6, 32'h0000_8081);
      expect_at(12, 1, 7, 32'h8081_8283);
      expect_at(12, 1, 8, 32'h8081_5583);
      repeat (14) @(negedge clk);

      #2;
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL t%0d %s[%0d]: never checked (due cycle %0d)",
                  e.tst, kname(e.kind), e.idx, e.cyc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
